// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbiter and sequencer between the multi-cycle CPU and the DMA/program
//   loader port for a single-port unified memory with 1-cycle synchronous
//   read. One access is in flight at a time: IDLE -> ISSUE -> RESP, with
//   RESP re-arbitrating so continuous traffic alternates ISSUE/RESP.
//
//   Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   : on contention grant the requester that was not last_owner
//                 (first contention after reset goes to the CPU).
//     undefined : fixed priority, CPU always wins; DMA may starve.
//
//   Ports
//     clk, reset            clock; asynchronous active-high reset
//     cpu_req/dma_req       access request, held with payload until granted
//     cpu_we/dma_we         1 = write, 0 = read
//     cpu_addr/dma_addr     access address            [ADDR_W]
//     cpu_wdata/dma_wdata   write data                [DATA_W]
//     cpu_gnt/dma_gnt       pulse: access on the memory bus this cycle
//     cpu_valid/dma_valid   pulse: access complete, read data valid
//     cpu_rdata/dma_rdata   read data, held until that port's next read
//     cpu_stall             cpu_req & ~cpu_valid
//     mem_addr/mem_we/mem_wdata  memory request, zero outside ISSUE
//     mem_rdata             memory read data, valid the cycle after address
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_valid,
  output logic              dma_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              wr_q, wr_d;
  logic              arb_win;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // In RESP last_owner already equals the current owner, so a requester
  // that just lost keeps its turn for the next ISSUE.
  always_comb begin
    if (cpu_req && dma_req) arb_win = ~last_owner_q;
    else if (cpu_req)       arb_win = OWN_CPU;
    else                    arb_win = OWN_DMA;
  end
`else
  // last_owner is still tracked in this build but plays no part in arbitration.
  logic last_owner_unused;
  assign last_owner_unused = last_owner_q;
  assign arb_win = cpu_req ? OWN_CPU : OWN_DMA;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wr_d         = wr_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    cpu_valid    = 1'b0;
    dma_valid    = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d = arb_win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Payload is taken straight from the owner's inputs; the requester
        // holds it stable until it has seen gnt.
        if (owner_q == OWN_CPU) begin
          cpu_gnt   = 1'b1;
          mem_addr  = cpu_addr;
          mem_we    = cpu_we;
          mem_wdata = cpu_wdata;
          wr_d      = cpu_we;
        end else begin
          dma_gnt   = 1'b1;
          mem_addr  = dma_addr;
          mem_we    = dma_we;
          mem_wdata = dma_wdata;
          wr_d      = dma_we;
        end
        last_owner_d = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        // The access type is latched in ISSUE because the requester may
        // already present a new payload during RESP.
        if (owner_q == OWN_CPU) begin
          cpu_valid = 1'b1;
          if (!wr_q) cpu_rdata_d = mem_rdata;
        end else begin
          dma_valid = 1'b1;
          if (!wr_q) dma_rdata_d = mem_rdata;
        end
        if (cpu_req || dma_req) begin
          owner_d = arb_win;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory data only arrives in RESP, so the read port is bypassed in that
  // cycle to present data together with valid; the register holds it after.
  assign cpu_rdata = cpu_rdata_d;
  assign dma_rdata = dma_rdata_d;
  assign cpu_stall = cpu_req & ~cpu_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;
      wr_q         <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wr_q         <= wr_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed scenarios plus a randomized
//   two-requester run checked against a transaction-level model (shadow
//   memory, grant/valid timing rules and the arbitration policy).
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, dma_gnt, cpu_valid, dma_valid, cpu_stall;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  int tests = 0;
  int fails = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_valid(cpu_valid), .dma_valid(dma_valid),
    .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory, synchronous read with 1-cycle latency, plus a
  // backdoor write port for preloading.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d; shadow[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    tests++; if ({cpu_gnt, dma_gnt, cpu_valid, dma_valid, mem_we, cpu_stall} !== 6'b0) begin fails++; $display("FAIL reset_ctrl: got %b expected 000000", {cpu_gnt, dma_gnt, cpu_valid, dma_valid, mem_we, cpu_stall}); end
    tests++; if ({mem_addr, mem_wdata} !== 16'h0) begin fails++; $display("FAIL reset_mem_bus: got %h expected 0000", {mem_addr, mem_wdata}); end
    tests++; if ({cpu_rdata, dma_rdata} !== 16'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0000", {cpu_rdata, dma_rdata}); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if ({cpu_gnt, dma_gnt} !== 2'b00) begin fails++; $display("FAIL reset_idle_gnt: got %b expected 00", {cpu_gnt, dma_gnt}); end
  endtask

  task automatic test_cpu_read();
    poke(8'h10, 8'hA5);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    @(negedge clk);
    tests++; if ({cpu_gnt, dma_gnt, mem_we, cpu_valid} !== 4'b1000) begin fails++; $display("FAIL cpu_read_gnt: got %b expected 1000", {cpu_gnt, dma_gnt, mem_we, cpu_valid}); end
    tests++; if (mem_addr !== 8'h10) begin fails++; $display("FAIL cpu_read_addr: got %h expected 10", mem_addr); end
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL cpu_read_stall_issue: got %b expected 1", cpu_stall); end
    cpu_req = 1'b0;
    @(negedge clk);
    tests++; if ({cpu_valid, cpu_gnt, mem_we} !== 3'b100) begin fails++; $display("FAIL cpu_read_valid: got %b expected 100", {cpu_valid, cpu_gnt, mem_we}); end
    tests++; if (cpu_rdata !== 8'hA5) begin fails++; $display("FAIL cpu_read_data: got %h expected a5", cpu_rdata); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL cpu_read_addr_resp: got %h expected 00", mem_addr); end
    @(negedge clk);
    tests++; if ({cpu_stall, cpu_valid} !== 2'b00) begin fails++; $display("FAIL cpu_read_after: got %b expected 00", {cpu_stall, cpu_valid}); end
    tests++; if (cpu_rdata !== 8'hA5) begin fails++; $display("FAIL cpu_read_hold: got %h expected a5", cpu_rdata); end
  endtask

  task automatic test_rdata_isolation();
    poke(8'h30, 8'h77);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h30;
    @(negedge clk);
    tests++; if ({dma_gnt, cpu_gnt} !== 2'b10) begin fails++; $display("FAIL iso_gnt: got %b expected 10", {dma_gnt, cpu_gnt}); end
    dma_req = 1'b0;
    @(negedge clk);
    tests++; if ({dma_valid, cpu_valid} !== 2'b10) begin fails++; $display("FAIL iso_valid: got %b expected 10", {dma_valid, cpu_valid}); end
    tests++; if (dma_rdata !== 8'h77) begin fails++; $display("FAIL iso_dma_data: got %h expected 77", dma_rdata); end
    tests++; if (cpu_rdata !== 8'hA5) begin fails++; $display("FAIL iso_cpu_data: got %h expected a5", cpu_rdata); end
    @(negedge clk);
    tests++; if ({cpu_rdata, dma_rdata} !== 16'hA577) begin fails++; $display("FAIL iso_hold: got %h expected a577", {cpu_rdata, dma_rdata}); end
  endtask

  task automatic test_dma_write_cpu_read();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 8'h3C;
    @(negedge clk);
    tests++; if ({dma_gnt, mem_we} !== 2'b11) begin fails++; $display("FAIL dw_issue: got %b expected 11", {dma_gnt, mem_we}); end
    tests++; if ({mem_addr, mem_wdata} !== 16'h203C) begin fails++; $display("FAIL dw_bus: got %h expected 203c", {mem_addr, mem_wdata}); end
    dma_req = 1'b0;
    @(negedge clk);
    tests++; if ({dma_valid, mem_we} !== 2'b10) begin fails++; $display("FAIL dw_resp: got %b expected 10", {dma_valid, mem_we}); end
    tests++; if (dma_rdata !== 8'h77) begin fails++; $display("FAIL dw_rdata_kept: got %h expected 77", dma_rdata); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    @(negedge clk);
    tests++; if ({cpu_gnt, mem_we} !== 2'b10) begin fails++; $display("FAIL dw_cpu_issue: got %b expected 10", {cpu_gnt, mem_we}); end
    cpu_req = 1'b0;
    @(negedge clk);
    tests++; if ({cpu_valid, mem_we} !== 2'b10) begin fails++; $display("FAIL dw_cpu_valid: got %b expected 10", {cpu_valid, mem_we}); end
    tests++; if (cpu_rdata !== 8'h3C) begin fails++; $display("FAIL dw_cpu_data: got %h expected 3c", cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [3:0] dma_seq;
    int         dma_gnts;
    dma_seq = RR ? 4'b1010 : 4'b0000;
    dma_gnts = 0;
    apply_reset();
    poke(8'h01, 8'h11);
    poke(8'h02, 8'h22);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h02;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dma_gnt === 1'b1) dma_gnts++;
      if (c % 2 == 1) begin
        tests++; if ({cpu_gnt, dma_gnt} !== {~dma_seq[c/2], dma_seq[c/2]}) begin fails++; $display("FAIL contention_grant%0d: got cpu/dma %b expected %b", c/2, {cpu_gnt, dma_gnt}, {~dma_seq[c/2], dma_seq[c/2]}); end
      end else begin
        tests++; if ({cpu_gnt, dma_gnt, cpu_valid ^ dma_valid} !== 3'b001) begin fails++; $display("FAIL contention_resp%0d: got gnt/valid %b expected 001", c/2, {cpu_gnt, dma_gnt, cpu_valid ^ dma_valid}); end
      end
    end
    tests++; if (dma_gnts != (RR ? 2 : 0)) begin fails++; $display("FAIL contention_dma_count: got %0d expected %0d", dma_gnts, RR ? 2 : 0); end
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    poke(8'h00, 8'h5A);
    poke(8'h01, 8'hC3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
    @(negedge clk);
    tests++; if ({cpu_gnt, mem_addr} !== {1'b1, 8'h00}) begin fails++; $display("FAIL b2b_gnt1: got %h expected 100", {cpu_gnt, mem_addr}); end
    cpu_req = 1'b0;
    @(negedge clk);
    tests++; if ({cpu_valid, cpu_rdata} !== {1'b1, 8'h5A}) begin fails++; $display("FAIL b2b_valid1: got %h expected 15a", {cpu_valid, cpu_rdata}); end
    cpu_req = 1'b1; cpu_addr = 8'h01;
    @(negedge clk);
    tests++; if ({cpu_gnt, cpu_valid, mem_addr} !== {2'b10, 8'h01}) begin fails++; $display("FAIL b2b_gnt2: got %h expected 201", {cpu_gnt, cpu_valid, mem_addr}); end
    cpu_req = 1'b0;
    @(negedge clk);
    tests++; if ({cpu_valid, cpu_rdata} !== {1'b1, 8'hC3}) begin fails++; $display("FAIL b2b_valid2: got %h expected 1c3", {cpu_valid, cpu_rdata}); end
    @(negedge clk);
  endtask

  task automatic test_reset_during_issue();
    poke(8'h40, 8'h55);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 8'h99;
    @(negedge clk);
    tests++; if ({dma_gnt, mem_we} !== 2'b11) begin fails++; $display("FAIL rst_issue_pre: got %b expected 11", {dma_gnt, mem_we}); end
    #2 reset = 1'b1;
    #1;
    tests++; if ({mem_we, dma_gnt, mem_addr} !== 10'h0) begin fails++; $display("FAIL rst_issue_we: got %h expected 000", {mem_we, dma_gnt, mem_addr}); end
    clear_inputs();
    @(negedge clk);
    tests++; if ({cpu_rdata, dma_rdata} !== 16'h0) begin fails++; $display("FAIL rst_issue_rdata: got %h expected 0000", {cpu_rdata, dma_rdata}); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if ({dma_valid, dma_gnt, cpu_valid} !== 3'b000) begin fails++; $display("FAIL rst_issue_novalid: got %b expected 000", {dma_valid, dma_gnt, cpu_valid}); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
    @(negedge clk);
    tests++; if (cpu_gnt !== 1'b1) begin fails++; $display("FAIL rst_issue_idle: got %b expected 1", cpu_gnt); end
    cpu_req = 1'b0;
    @(negedge clk);
    tests++; if ({cpu_valid, cpu_rdata} !== {1'b1, 8'h55}) begin fails++; $display("FAIL rst_issue_nowrite: got %h expected 155", {cpu_valid, cpu_rdata}); end
    @(negedge clk);
  endtask

  // Transaction-level model: a grant is due in the cycle after any request
  // was visible in a non-grant cycle; the winner follows the policy; valid
  // follows grant by one cycle; read data comes from a shadow memory that is
  // updated in grant order.
  task automatic test_random();
    logic          s_c, s_d, s_any, v_c, v_d, rd_c, rd_d, last_w, exp_g, win, eg_c, eg_d;
    logic [DW-1:0] pv_c, pv_d, er_c, er_d;
    apply_reset();
    for (int a = 0; a < 8; a++) poke(8'(a), 8'($urandom));
    s_c = 0; s_d = 0; s_any = 0; v_c = 0; v_d = 0; rd_c = 0; rd_d = 0;
    last_w = 1'b1; er_c = '0; er_d = '0; pv_c = '0; pv_d = '0;
    for (int cyc = 0; cyc < 640; cyc++) begin
      @(negedge clk);
      exp_g = (s_c | s_d) & ~s_any;
      if (s_c && s_d) win = RR ? ~last_w : 1'b0;
      else            win = s_d;
      eg_c = exp_g & ~win;
      eg_d = exp_g & win;
      tests++; if ({cpu_gnt, dma_gnt} !== {eg_c, eg_d}) begin fails++; $display("FAIL rnd_gnt cyc%0d: got %b expected %b", cyc, {cpu_gnt, dma_gnt}, {eg_c, eg_d}); end
      tests++; if ({cpu_valid, dma_valid} !== {v_c, v_d}) begin fails++; $display("FAIL rnd_valid cyc%0d: got %b expected %b", cyc, {cpu_valid, dma_valid}, {v_c, v_d}); end
      if (v_c && rd_c) er_c = pv_c;
      if (v_d && rd_d) er_d = pv_d;
      tests++; if ({cpu_rdata, dma_rdata} !== {er_c, er_d}) begin fails++; $display("FAIL rnd_rdata cyc%0d: got %h expected %h", cyc, {cpu_rdata, dma_rdata}, {er_c, er_d}); end
      tests++; if (cpu_stall !== (cpu_req & ~v_c)) begin fails++; $display("FAIL rnd_stall cyc%0d: got %b expected %b", cyc, cpu_stall, cpu_req & ~v_c); end
      if (eg_c) begin
        tests++; if ({mem_we, mem_addr, mem_wdata} !== {cpu_we, cpu_addr, cpu_wdata}) begin fails++; $display("FAIL rnd_cpu_bus cyc%0d: got %h expected %h", cyc, {mem_we, mem_addr, mem_wdata}, {cpu_we, cpu_addr, cpu_wdata}); end
        rd_c = ~cpu_we; pv_c = shadow[cpu_addr];
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
        last_w = 1'b0;
      end else if (eg_d) begin
        tests++; if ({mem_we, mem_addr, mem_wdata} !== {dma_we, dma_addr, dma_wdata}) begin fails++; $display("FAIL rnd_dma_bus cyc%0d: got %h expected %h", cyc, {mem_we, mem_addr, mem_wdata}, {dma_we, dma_addr, dma_wdata}); end
        rd_d = ~dma_we; pv_d = shadow[dma_addr];
        if (dma_we) shadow[dma_addr] = dma_wdata;
        last_w = 1'b1;
      end else begin
        tests++; if ({mem_we, mem_addr, mem_wdata} !== 17'h0) begin fails++; $display("FAIL rnd_bus_idle cyc%0d: got %h expected 0", cyc, {mem_we, mem_addr, mem_wdata}); end
      end
      v_c = eg_c; v_d = eg_d; s_any = exp_g;
      if (eg_c) cpu_req = 1'b0;
      else if (!cpu_req && cyc < 600 && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 8'($urandom_range(0, 7)); cpu_wdata = 8'($urandom);
      end
      if (eg_d) dma_req = 1'b0;
      else if (!dma_req && cyc < 600 && $urandom_range(0, 2) == 0) begin
        dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = 8'($urandom_range(0, 7)); dma_wdata = 8'($urandom);
      end
      s_c = cpu_req; s_d = dma_req;
    end
    tests++; if ({cpu_req, dma_req} !== 2'b00) begin fails++; $display("FAIL rnd_drain: requests still pending %b expected 00", {cpu_req, dma_req}); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_rdata_isolation();
    test_dma_write_cpu_read();
    test_contention();
    test_back_to_back();
    test_reset_during_issue();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
